// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive FIFO that captures bytes on rising rx_valid, with a sticky overrun flag and a level irq
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8,
    parameter int IRQ_LEVEL  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      rx_data,
    input  logic                  rx_valid,
    input  logic                  rd_req,
    input  logic                  ovr_clr,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overrun,
    output logic                  irq
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = DEPTH;
    localparam logic [DEPTH_LOG2:0]   IRQ_CNT  = IRQ_LEVEL;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  rx_valid_q, overrun_q, overrun_d;
    logic                  push, pop_ok, wr_en, drop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign count   = count_q;
    assign overrun = overrun_q;
    assign irq     = (count_q >= IRQ_CNT) | overrun_q;
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    // Rising-edge push detect, pop qualification and next-state of pointers, count and overrun
    always_comb begin
        push      = rx_valid & ~rx_valid_q;
        pop_ok    = rd_req & ~empty;
        wr_en     = push & (~full | pop_ok);
        drop      = push & full & ~pop_ok;
        wr_ptr_d  = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d  = pop_ok ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d   = (wr_en & ~pop_ok) ? count_q + CNT_ONE :
                    (pop_ok & ~wr_en) ? count_q - CNT_ONE : count_q;
        overrun_d = drop ? 1'b1 : ovr_clr ? 1'b0 : overrun_q;
    end

    // Storage array is deliberately left unreset; only pointers decide what is valid
    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem_q[wr_ptr_q] <= rx_data;
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed stimulus with a queue scoreboard checked on every accepted read
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       rst, rx_valid, rd_req, ovr_clr;
    logic [7:0] rx_data, dout;
    logic       empty, full, overrun, irq;
    logic [4:0] count;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(.DEPTH_LOG2(4), .WIDTH(8), .IRQ_LEVEL(1)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rd_req(rd_req), .ovr_clr(ovr_clr), .dout(dout), .empty(empty),
        .full(full), .count(count), .overrun(overrun), .irq(irq)
    );

    always #5 clk = ~clk;

    // Monitor: every read the DUT accepts must return the oldest expected byte
    always @(negedge clk) begin
        if (!rst && rd_req && !empty) begin
            total_cnt++;
            if (exp_q.size() == 0)
                $display("FAIL read_unexpected: got %02h, scoreboard empty", dout);
            else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (dout === e) pass_cnt++;
                else $display("FAIL read_data: got %02h, expected %02h", dout, e);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic push_byte(input logic [7:0] d, input bit stored);
        @(posedge clk); #1;
        rx_data = d; rx_valid = 1'b1;
        if (stored) exp_q.push_back(d);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic pop_one();
        @(posedge clk); #1;
        rd_req = 1'b1;
        @(posedge clk); #1;
        rd_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rd_req = 1'b0; ovr_clr = 1'b0; rx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_count", 32'(count), 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_dout", 32'(dout), 0);

        push_byte(8'h41, 1);
        check("fwft_latency", 32'(dout), 32'h41);
        push_byte(8'h42, 1);
        push_byte(8'h43, 1);
        check("three_count", 32'(count), 3);
        check("three_dout", 32'(dout), 32'h41);
        check("three_irq", 32'(irq), 1);
        pop_one();
        check("pop1_dout", 32'(dout), 32'h42);
        pop_one();
        check("pop2_dout", 32'(dout), 32'h43);
        pop_one();
        check("pop3_empty", 32'(empty), 1);

        @(posedge clk); #1;
        rx_data = 8'h55; rx_valid = 1'b1; exp_q.push_back(8'h55);
        repeat (5) @(posedge clk);
        #1 rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("held_count", 32'(count), 1);
        pop_one();

        for (int i = 0; i < 16; i++) push_byte(8'(i), 1);
        check("fill_full", 32'(full), 1);
        push_byte(8'h99, 0);
        check("drop_overrun", 32'(overrun), 1);
        check("drop_count", 32'(count), 16);
        check("drop_dout", 32'(dout), 32'h00);
        for (int i = 0; i < 16; i++) pop_one();
        check("drain_empty", 32'(empty), 1);

        @(posedge clk); #1 ovr_clr = 1'b1;
        @(posedge clk); #1 ovr_clr = 1'b0;
        for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i), 1);
        @(posedge clk); #1;
        rx_data = 8'hA5; rx_valid = 1'b1; rd_req = 1'b1; exp_q.push_back(8'hA5);
        @(posedge clk); #1;
        rx_valid = 1'b0; rd_req = 1'b0;
        check("swap_count", 32'(count), 16);
        check("swap_overrun", 32'(overrun), 0);
        for (int i = 0; i < 16; i++) pop_one();
        check("swap_drained", 32'(empty), 1);

        for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i), 1);
        push_byte(8'h77, 0);
        check("ovr_set", 32'(overrun), 1);
        @(posedge clk); #1;
        rx_data = 8'h78; rx_valid = 1'b1; ovr_clr = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; ovr_clr = 1'b0;
        check("ovr_set_wins", 32'(overrun), 1);
        @(posedge clk); #1 ovr_clr = 1'b1;
        @(posedge clk); #1 ovr_clr = 1'b0;
        check("ovr_cleared", 32'(overrun), 0);
        for (int i = 0; i < 9; i++) pop_one();
        check("pre_rst_count", 32'(count), 7);
        @(posedge clk); #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        check("midrst_empty", 32'(empty), 1);
        check("midrst_count", 32'(count), 0);
        check("midrst_dout", 32'(dout), 0);
        check("midrst_irq", 32'(irq), 0);
        pop_one();
        check("rd_empty_count", 32'(count), 0);
        check("rd_empty_empty", 32'(empty), 1);
        push_byte(8'h3C, 1);
        check("post_rst_dout", 32'(dout), 32'h3C);
        check("post_rst_count", 32'(count), 1);
        pop_one();
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
